// File: rtl/core_pkg.sv
// Shared definitions for the RV32IC front end: reset/bubble defaults, fetch
// state encoding, RVC quadrant/funct3 codes, RV32I opcodes and field packers.
package core_pkg;

  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic {FETCH, SPLIT} fetch_state_e;

  localparam logic [1:0] RVC_C0 = 2'b00;
  localparam logic [1:0] RVC_C1 = 2'b01;
  localparam logic [1:0] RVC_C2 = 2'b10;

  localparam logic [2:0] C0_ADDI4SPN = 3'b000;
  localparam logic [2:0] C0_LW       = 3'b010;
  localparam logic [2:0] C0_SW       = 3'b110;
  localparam logic [2:0] C1_ADDI     = 3'b000;
  localparam logic [2:0] C1_JAL      = 3'b001;
  localparam logic [2:0] C1_LI       = 3'b010;
  localparam logic [2:0] C1_LUI      = 3'b011;
  localparam logic [2:0] C1_ALU      = 3'b100;
  localparam logic [2:0] C1_J        = 3'b101;
  localparam logic [2:0] C1_BEQZ     = 3'b110;
  localparam logic [2:0] C1_BNEZ     = 3'b111;
  localparam logic [2:0] C2_SLLI     = 3'b000;
  localparam logic [2:0] C2_LWSP     = 3'b010;
  localparam logic [2:0] C2_JR       = 3'b100;
  localparam logic [2:0] C2_SWSP     = 3'b110;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] OP     = 7'b0110011;

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OP};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], STORE};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {imm[12], imm[10:5], 5'd0, rs1, f3, imm[4:1], imm[11], BRANCH};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, JAL};
  endfunction

endpackage

// File: rtl/fetch_align_unit_rvc_expander.sv
// Combinational RVC -> RV32I expander; built only when RVC_EXPAND_EN is defined.
// Unsupported or illegal halfwords (including 16'h0000) yield 32'h0000_0000.
`ifdef RVC_EXPAND_EN
module rvc_expander
  import core_pkg::*;
(
  input  logic [15:0] c_inst,
  output logic [31:0] inst
);

  logic [4:0]  rd, rs2, rdp, rs1p;
  logic [11:0] imm6_sx;
  logic [20:0] joff;
  logic [12:0] boff;
  logic [9:0]  nzuimm, sp16;
  logic [6:0]  lwoff;

  always_comb begin
    rd      = c_inst[11:7];
    rs2     = c_inst[6:2];
    rdp     = {2'b01, c_inst[4:2]};
    rs1p    = {2'b01, c_inst[9:7]};
    imm6_sx = {{6{c_inst[12]}}, c_inst[12], c_inst[6:2]};
    joff    = {{10{c_inst[12]}}, c_inst[8], c_inst[10:9], c_inst[6], c_inst[7],
               c_inst[2], c_inst[11], c_inst[5:3], 1'b0};
    boff    = {{5{c_inst[12]}}, c_inst[6:5], c_inst[2], c_inst[11:10], c_inst[4:3], 1'b0};
    nzuimm  = {c_inst[10:7], c_inst[12:11], c_inst[5], c_inst[6], 2'b00};
    sp16    = {c_inst[12], c_inst[4:3], c_inst[5], c_inst[2], c_inst[6], 4'b0000};
    lwoff   = {c_inst[5], c_inst[12:10], c_inst[6], 2'b00};
    inst    = '0;
    unique case (c_inst[1:0])
      RVC_C0: case (c_inst[15:13])
        C0_ADDI4SPN: if (nzuimm != '0) inst = enc_i({2'b00, nzuimm}, 5'd2, 3'b000, rdp, OP_IMM);
        C0_LW:       inst = enc_i({5'd0, lwoff}, rs1p, 3'b010, rdp, LOAD);
        C0_SW:       inst = enc_s({5'd0, lwoff}, rdp, rs1p);
        default:     inst = '0;
      endcase
      RVC_C1: case (c_inst[15:13])
        C1_ADDI: inst = enc_i(imm6_sx, rd, 3'b000, rd, OP_IMM);
        C1_JAL:  inst = enc_j(joff, 5'd1);
        C1_LI:   inst = enc_i(imm6_sx, 5'd0, 3'b000, rd, OP_IMM);
        C1_LUI:
          if (rd == 5'd2) begin
            if (sp16 != '0) inst = enc_i({{2{sp16[9]}}, sp16}, 5'd2, 3'b000, 5'd2, OP_IMM);
          end else if (imm6_sx != '0) begin
            inst = {{8{imm6_sx[11]}}, imm6_sx, rd, LUI};
          end
        C1_ALU: case (c_inst[11:10])
          2'b00: if (!c_inst[12]) inst = enc_i({7'd0, rs2}, rs1p, 3'b101, rs1p, OP_IMM);
          2'b01: if (!c_inst[12]) inst = enc_i({7'b0100000, rs2}, rs1p, 3'b101, rs1p, OP_IMM);
          2'b10: inst = enc_i(imm6_sx, rs1p, 3'b111, rs1p, OP_IMM);
          default:
            if (!c_inst[12]) begin
              case (c_inst[6:5])
                2'b00:   inst = enc_r(7'b0100000, rdp, rs1p, 3'b000, rs1p);
                2'b01:   inst = enc_r(7'd0, rdp, rs1p, 3'b100, rs1p);
                2'b10:   inst = enc_r(7'd0, rdp, rs1p, 3'b110, rs1p);
                default: inst = enc_r(7'd0, rdp, rs1p, 3'b111, rs1p);
              endcase
            end
        endcase
        C1_J:    inst = enc_j(joff, 5'd0);
        C1_BEQZ: inst = enc_b(boff, rs1p, 3'b000);
        default: inst = enc_b(boff, rs1p, 3'b001);
      endcase
      RVC_C2: case (c_inst[15:13])
        C2_SLLI: if (!c_inst[12]) inst = enc_i({7'd0, rs2}, rd, 3'b001, rd, OP_IMM);
        C2_LWSP: if (rd != '0)
                   inst = enc_i({4'd0, c_inst[3:2], c_inst[12], c_inst[6:4], 2'b00},
                                5'd2, 3'b010, rd, LOAD);
        C2_JR:
          if (rs2 == '0) begin
            if (rd != '0) inst = enc_i(12'd0, rd, 3'b000, {4'd0, c_inst[12]}, JALR);
          end else begin
            inst = enc_r(7'd0, rs2, c_inst[12] ? rd : 5'd0, 3'b000, rd);
          end
        C2_SWSP: inst = enc_s({4'd0, c_inst[8:7], c_inst[12:9], 2'b00}, rs2, 5'd2);
        default: inst = '0;
      endcase
      default: inst = '0;
    endcase
  end

endmodule
`endif

// File: rtl/fetch_align_unit.sv
// IF stage + IF/ID register for RV32IC: aligns 16/32-bit instructions out of
// 32-bit fetch words. Define RVC_EXPAND_EN to expand RVC to RV32I in IF.
module fetch_align_unit
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Stall,
  input  logic        Flush,
  input  logic [31:0] Redirect_PC,
  output logic [31:0] IMem_Addr,
  input  logic [31:0] IMem_Data,
  output logic [31:0] IF_ID_PC,
  output logic [31:0] IF_ID_Inst,
  output logic        IF_ID_Compressed,
  output logic        IF_ID_Valid
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d, id_pc_q, id_pc_d, id_inst_q, id_inst_d;
  logic [15:0]  hbuf_q, hbuf_d, half;
  logic [31:0]  inst16;
  logic         id_c_q, id_c_d, id_v_q, id_v_d;

  assign half = pc_q[1] ? IMem_Data[31:16] : IMem_Data[15:0];

`ifdef RVC_EXPAND_EN
  rvc_expander u_rvc_expander (.c_inst(half), .inst(inst16));
`else
  assign inst16 = {16'h0000, half};
`endif

  always_comb begin
    // SPLIT reads the word after pc to fetch the upper half of a straddler.
    IMem_Addr = (state_q == SPLIT) ? {pc_q[31:2] + 30'd1, 2'b00} : {pc_q[31:2], 2'b00};
    state_d   = state_q;
    pc_d      = pc_q;
    hbuf_d    = hbuf_q;
    id_pc_d   = id_pc_q;
    id_inst_d = id_inst_q;
    id_c_d    = id_c_q;
    id_v_d    = id_v_q;
    if (Flush) begin
      pc_d      = Redirect_PC & 32'hFFFF_FFFE;
      state_d   = FETCH;
      hbuf_d    = '0;
      id_inst_d = NOP_INST;
      id_c_d    = 1'b0;
      id_v_d    = 1'b0;
    end else if (!Stall) begin
      id_pc_d = pc_q;
      id_v_d  = 1'b1;
      id_c_d  = 1'b0;
      if (state_q == SPLIT) begin
        id_inst_d = {IMem_Data[15:0], hbuf_q};
        pc_d      = pc_q + 32'd4;
        state_d   = FETCH;
      end else if (half[1:0] != 2'b11) begin
        id_inst_d = inst16;
        id_c_d    = 1'b1;
        pc_d      = pc_q + 32'd2;
      end else if (!pc_q[1]) begin
        id_inst_d = IMem_Data;
        pc_d      = pc_q + 32'd4;
      end else begin
        // Straddler: park the low half and insert one bubble.
        hbuf_d    = half;
        state_d   = SPLIT;
        id_pc_d   = id_pc_q;
        id_inst_d = NOP_INST;
        id_v_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      hbuf_q    <= '0;
      id_pc_q   <= '0;
      id_inst_q <= NOP_INST;
      id_c_q    <= 1'b0;
      id_v_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      hbuf_q    <= hbuf_d;
      id_pc_q   <= id_pc_d;
      id_inst_q <= id_inst_d;
      id_c_q    <= id_c_d;
      id_v_q    <= id_v_d;
    end
  end

  assign IF_ID_PC         = id_pc_q;
  assign IF_ID_Inst       = id_inst_q;
  assign IF_ID_Compressed = id_c_q;
  assign IF_ID_Valid      = id_v_q;

endmodule

// File: tb/tb_fetch_align_unit.sv
// Bench for fetch_align_unit: halfword-level instruction-stream model checked
// every cycle, plus literal expectations at the interesting points.
module tb_fetch_align_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        Stall, Flush;
  logic [31:0] Redirect_PC, IMem_Addr, IMem_Data, IF_ID_PC, IF_ID_Inst;
  logic        IF_ID_Compressed, IF_ID_Valid;
  logic [31:0] mem [64];
  int          compared = 0;
  int          mismatched = 0;

  fetch_align_unit #(.RESET_PC(32'h0000_0000), .NOP_INST(32'h0000_0013)) dut (
    .clk(clk), .rst(rst), .Stall(Stall), .Flush(Flush), .Redirect_PC(Redirect_PC),
    .IMem_Addr(IMem_Addr), .IMem_Data(IMem_Data), .IF_ID_PC(IF_ID_PC),
    .IF_ID_Inst(IF_ID_Inst), .IF_ID_Compressed(IF_ID_Compressed), .IF_ID_Valid(IF_ID_Valid)
  );

  always #5 clk = ~clk;
  assign IMem_Data = mem[IMem_Addr[7:2]];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: walks the instruction stream halfword by halfword.
  logic [31:0] m_pc = '0, m_id_pc = '0, m_inst = 32'h13;
  logic        m_c = 1'b0, m_v = 1'b0, m_pend = 1'b0;

  function automatic logic [15:0] half_at(input logic [31:0] a);
    logic [31:0] w;
    w = mem[a[7:2]];
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  function automatic logic [31:0] exp16(input logic [15:0] h);
`ifdef RVC_EXPAND_EN
    case (h)
      16'h4501: return 32'h0000_0513;
      16'h8082: return 32'h0000_8067;
      16'h0001: return 32'h0000_0013;
      default:  return 32'h0000_0000;
    endcase
`else
    return {16'h0000, h};
`endif
  endfunction

  always @(posedge clk or negedge rst) begin
    logic [15:0] h;
    if (!rst) begin
      m_pc = '0; m_pend = 1'b0; m_id_pc = '0; m_inst = 32'h13; m_c = 1'b0; m_v = 1'b0;
    end else if (Flush) begin
      m_pc = {Redirect_PC[31:1], 1'b0}; m_pend = 1'b0;
      m_inst = 32'h13; m_c = 1'b0; m_v = 1'b0;
    end else if (!Stall) begin
      h = half_at(m_pc);
      if (h[1:0] != 2'b11) begin
        m_id_pc = m_pc; m_inst = exp16(h); m_c = 1'b1; m_v = 1'b1; m_pc = m_pc + 2;
      end else if (!m_pc[1]) begin
        m_id_pc = m_pc; m_inst = mem[m_pc[7:2]]; m_c = 1'b0; m_v = 1'b1; m_pc = m_pc + 4;
      end else if (!m_pend) begin
        m_pend = 1'b1; m_inst = 32'h13; m_c = 1'b0; m_v = 1'b0;
      end else begin
        m_id_pc = m_pc; m_inst = {half_at(m_pc + 2), h}; m_c = 1'b0; m_v = 1'b1;
        m_pc = m_pc + 4; m_pend = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    chk("imem_addr", IMem_Addr, {m_pc[31:2], 2'b00} + (m_pend ? 32'd4 : 32'd0));
    chk("valid", {31'd0, IF_ID_Valid}, {31'd0, m_v});
    chk("inst", IF_ID_Inst, m_inst);
    chk("compressed", {31'd0, IF_ID_Compressed}, {31'd0, m_c});
    if (m_v) chk("if_id_pc", IF_ID_PC, m_id_pc);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic lit(input string nm, input logic [31:0] pc, input logic [31:0] inst,
                     input logic c, input logic v);
    chk({nm, "_valid"}, {31'd0, IF_ID_Valid}, {31'd0, v});
    chk({nm, "_inst"}, IF_ID_Inst, inst);
    chk({nm, "_comp"}, {31'd0, IF_ID_Compressed}, {31'd0, c});
    if (v) chk({nm, "_pc"}, IF_ID_PC, pc);
  endtask

  localparam logic [31:0] I4501 =
`ifdef RVC_EXPAND_EN
    32'h0000_0513;
`else
    32'h0000_4501;
`endif
  localparam logic [31:0] I8082 =
`ifdef RVC_EXPAND_EN
    32'h0000_8067;
`else
    32'h0000_8082;
`endif

  initial begin
    Stall = 1'b0; Flush = 1'b0; Redirect_PC = '0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0013;
    mem[0]  = 32'h00A0_0093;
    mem[1]  = 32'h0513_4501;
    mem[2]  = 32'h8082_0010;
    mem[3]  = 32'h0000_0000;
    mem[63] = 32'h0513_0001;
    #1 rst = 1'b0;
    cyc(2);
    lit("reset", 32'h0, 32'h13, 1'b0, 1'b0);
    chk("reset_addr", IMem_Addr, 32'h0);
    rst = 1'b1;
    cyc(1); lit("first", 32'h0, 32'h00A0_0093, 1'b0, 1'b1);
    cyc(1); lit("rvc4", 32'h4, I4501, 1'b1, 1'b1);
    cyc(1); lit("bubble6", 32'h0, 32'h13, 1'b0, 1'b0);
    chk("bubble6_addr", IMem_Addr, 32'h8);
    cyc(1); lit("split6", 32'h6, 32'h0010_0513, 1'b0, 1'b1);
    cyc(1); lit("rvcA", 32'hA, I8082, 1'b1, 1'b1);
    cyc(1); lit("zeroC", 32'hC, 32'h0, 1'b1, 1'b1);
    cyc(1); lit("zeroE", 32'hE, 32'h0, 1'b1, 1'b1);
    cyc(2);
    // Asynchronous reset in the middle of a run.
    rst = 1'b0;
    #2 lit("midreset", 32'h0, 32'h13, 1'b0, 1'b0);
    chk("midreset_addr", IMem_Addr, 32'h0);
    cyc(1); rst = 1'b1;
    cyc(1); lit("rerun", 32'h0, 32'h00A0_0093, 1'b0, 1'b1);
    cyc(1); lit("rerun4", 32'h4, I4501, 1'b1, 1'b1);
    cyc(1); chk("split_addr", IMem_Addr, 32'h8);
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("stall_addr", IMem_Addr, 32'h8);
      chk("stall_valid", {31'd0, IF_ID_Valid}, 32'd0);
    end
    Stall = 1'b0;
    cyc(1); lit("afterstall", 32'h6, 32'h0010_0513, 1'b0, 1'b1);
    Stall = 1'b1; cyc(2); lit("holdvalid", 32'h6, 32'h0010_0513, 1'b0, 1'b1);
    Flush = 1'b1; Redirect_PC = 32'h101;
    cyc(1); lit("flushstall", 32'h0, 32'h13, 1'b0, 1'b0);
    chk("flushstall_addr", IMem_Addr, 32'h100);
    Flush = 1'b0; Stall = 1'b0;
    cyc(1); lit("at100", 32'h100, 32'h00A0_0093, 1'b0, 1'b1);
    Flush = 1'b1; Redirect_PC = 32'h4;
    cyc(1); Flush = 1'b0;
    cyc(2); chk("split_again", IMem_Addr, 32'h8);
    Flush = 1'b1; Redirect_PC = 32'hC;
    cyc(1); lit("flushsplit", 32'h0, 32'h13, 1'b0, 1'b0);
    chk("flushsplit_addr", IMem_Addr, 32'hC);
    Flush = 1'b0;
    cyc(1); lit("atC", 32'hC, 32'h0, 1'b1, 1'b1);
    Flush = 1'b1; Redirect_PC = 32'hFFFF_FFFF;
    cyc(1); chk("wrap_fetch_addr", IMem_Addr, 32'hFFFF_FFFC);
    Flush = 1'b0;
    cyc(1); chk("wrap_split_addr", IMem_Addr, 32'h0);
    chk("wrap_bubble", {31'd0, IF_ID_Valid}, 32'd0);
    cyc(1); lit("wrap_issue", 32'hFFFF_FFFE, 32'h0093_0513, 1'b0, 1'b1);
    chk("wrap_next_addr", IMem_Addr, 32'h0);
    Flush = 1'b1; Redirect_PC = 32'h0;
    cyc(1); Flush = 1'b0;
    cyc(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
